// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: queues IF predictions, checks them at EX, issues flush/redirect and training updates.
// Optional performance counters are enabled with BRU_PERF_CNT_EN.
module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_pred_valid,
    input  logic [31:0]      i_pred_pc,
    input  logic             i_pred_taken,
    input  logic [31:0]      i_pred_target,
    output logic             o_pred_ready,
    input  logic             i_stall,
    input  logic             i_res_valid,
    input  logic [31:0]      i_res_pc,
    input  logic             i_res_taken,
    input  logic [31:0]      i_res_target,
    output logic             o_flush,
    output logic [31:0]      o_redirect_pc,
    output logic             o_upd_valid,
    output logic [31:0]      o_upd_pc,
    output logic             o_upd_taken,
    output logic [31:0]      o_upd_target,
    output logic             o_error,
    output logic [CNT_W-1:0] o_branch_cnt,
    output logic [CNT_W-1:0] o_mispred_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } ent_t;

    ent_t          q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [0:0]    state;

    ent_t        head;
    logic        push;
    logic        pop;
    logic        err;
    logic        mis;
    logic [31:0] fix_pc;

    assign head         = q[rd_ptr];
    assign o_pred_ready = (count < (PW+1)'(DEPTH)) && (state == ST_RUN);
    assign push         = i_pred_valid & o_pred_ready & ~i_stall;
    assign pop          = i_res_valid & ~i_stall & (state == ST_RUN);

    // An empty-queue resolve has a stale head, so err must dominate mis.
    assign err    = pop & ((count == '0) | (head.pc != i_res_pc));
    assign mis    = pop & (err
                    | (head.taken != i_res_taken)
                    | (i_res_taken & (head.target != i_res_target)));
    assign fix_pc = i_res_taken ? i_res_target : i_res_pc + 32'd4;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= ST_RUN;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else if (state == ST_FLUSH) begin
            if (!i_stall) begin
                state <= ST_RUN;
            end
        end else if (mis) begin
            state  <= ST_FLUSH;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                q[wr_ptr] <= '{pc: i_pred_pc, taken: i_pred_taken,
                               target: i_pred_target};
                wr_ptr    <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + (PW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_flush       <= 1'b0;
            o_redirect_pc <= '0;
            o_upd_valid   <= 1'b0;
            o_upd_pc      <= '0;
            o_upd_taken   <= 1'b0;
            o_upd_target  <= '0;
            o_error       <= 1'b0;
        end else begin
            o_flush     <= mis;
            o_upd_valid <= pop;
            o_error     <= o_error | err;
            if (mis) begin
                o_redirect_pc <= fix_pc;
            end
            if (pop) begin
                o_upd_pc     <= i_res_pc;
                o_upd_taken  <= i_res_taken;
                o_upd_target <= i_res_target;
            end
        end
    end

`ifdef BRU_PERF_CNT_EN
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (pop && !(&branch_cnt)) begin
                branch_cnt <= branch_cnt + CNT_W'(1);
            end
            if (mis && !(&mispred_cnt)) begin
                mispred_cnt <= mispred_cnt + CNT_W'(1);
            end
        end
    end

    assign o_branch_cnt  = branch_cnt;
    assign o_mispred_cnt = mispred_cnt;
`else
    assign o_branch_cnt  = '0;
    assign o_mispred_cnt = '0;
`endif

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-side counterpart of the fetch-stage branch predictor. It captures every prediction issued at IF into an in-flight queue, checks it against the actual outcome when the instruction resolves in EX, and issues the flush/redirect and the predictor-training update. Sits between the IF prediction port and the EX branch comparator / ALU target path.

## Interface
- DEPTH, 4, in-flight prediction entries; power of two, ≥2
- CNT_W, 32, width of performance counters
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  reset; asynchronous, active-low
- i_pred_valid  in  1  IF issues a control-flow instruction (B-type/JAL/JALR) with a prediction
- i_pred_pc  in  32  PC of that instruction
- i_pred_taken  in  1  predicted direction
- i_pred_target  in  32  predicted target (ignored when not taken)
- o_pred_ready  out  1  queue can accept; = (count < DEPTH) and state == RUN
- i_stall  in  1  pipeline hold; no push or resolve accepted while high
- i_res_valid  in  1  EX resolves the oldest control-flow instruction
- i_res_pc  in  32  PC of resolving instruction
- i_res_taken  in  1  actual direction
- i_res_target  in  32  actual target (ALU result)
- o_flush  out  1  registered one-cycle misprediction pulse
- o_redirect_pc  out  32  correct next PC, valid with o_flush
- o_upd_valid  out  1  registered one-cycle predictor-training strobe
- o_upd_pc / o_upd_taken / o_upd_target  out  32/1/32  training data
- o_error  out  1  sticky protocol error
- o_branch_cnt  out  CNT_W  resolved control-flow instructions
- o_mispred_cnt  out  CNT_W  mispredictions

## Operation
- Queue: circular FIFO of {pc, taken, target}, read/write pointers mod DEPTH, count 0..DEPTH.
- Push: i_pred_valid & o_pred_ready & ~i_stall. Pop: i_res_valid & ~i_stall & state==RUN.
- Push and pop same cycle: both occur, count unchanged; allowed at full only if pop also occurs? No — ready is computed from current count, no bypass.
- Check at pop against head: mispredict = (head.taken != i_res_taken) | (i_res_taken & head.target != i_res_target).
- Protocol error: pop with count==0, or head.pc != i_res_pc. Sets o_error (sticky to reset) and is treated as mispredict.
- Correct PC: i_res_taken ? i_res_target : i_res_pc + 4 (mod 2^32).
- FSM, two states:
  - RUN: normal; on pop with mispredict/error -> FLUSH, queue cleared (pointers and count to 0), any same-cycle push discarded.
  - FLUSH: one cycle, o_flush=1; pushes and resolves ignored; -> RUN.
- Every pop produces o_upd_* with i_res_pc, i_res_taken, i_res_target, regardless of outcome.
- Counters increment on pop (branch) and on mispredict/error (mispred); saturate at all-ones.

## Timing
- Reset: state RUN, queue empty, o_pred_ready=1, o_flush=0, o_redirect_pc=0, o_upd_valid=0, o_upd_*=0, o_error=0, counters=0.
- Resolve accepted at edge t -> o_upd_valid, o_flush, o_redirect_pc valid during cycle t+1 for exactly one cycle.
- o_pred_ready low during FLUSH cycle; returns high at t+2 (queue empty).
- Back-to-back correct resolves: one update per cycle, no bubbles.
- Reset asserted mid-FLUSH: all state/outputs to reset values immediately; no pulse completes.
- i_stall high: queue, FSM, counters hold; pending registered pulses still drop after one cycle.

## Configuration
- BRU_PERF_CNT_EN defined: o_branch_cnt/o_mispred_cnt implemented as above.
- Not defined: counter registers removed, both outputs tied to 0; all other behaviour identical.

## Test plan
- Reset then idle: all outputs at reset values, o_pred_ready=1 for 10 cycles.
- Push pc=0x100 taken target=0x200; resolve pc=0x100 taken target=0x200 -> next cycle o_upd_valid=1, o_upd_target=0x200, o_flush=0, branch_cnt=1.
- Push pc=0x40 not-taken; resolve taken target=0x80 -> o_flush=1, o_redirect_pc=0x80, mispred_cnt=1, queue empty, o_pred_ready=0 that cycle.
- Push pc=0xFFFFFFFC taken; resolve not-taken -> o_redirect_pc=0x00000000 (wrap).
- Push 4 entries (DEPTH=4) -> o_pred_ready=0; 5th push ignored; simultaneous pop+push at count 3 keeps count 3; resolve all in order with no flush.
- Resolve pc=0x300 with empty queue -> o_error=1 sticky, o_flush=1, o_redirect_pc per outcome; o_error stays 1 until i_rst_n low.
